// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between an instruction-fetch
// requester and a load/store requester. At most one access is issued per cycle.
// Grants are combinational in the request cycle. A rotating priority flag keeps
// a continuously contending fetch from starving. Read data ownership travels
// through a LAT-deep tag pipeline, so each read response is steered back to the
// requester that issued it. The response is never steered by the current grant.
module mem_port_arbiter #(
    parameter int AW  = 32,
    parameter int LAT = 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_gnt_o,
    output logic          if_rvalid_o,
    output logic [31:0]   if_rdata_o,
    input  logic          ls_req_i,
    input  logic          ls_we_i,
    input  logic [AW-1:0] ls_addr_i,
    input  logic [31:0]   ls_wdata_i,
    output logic          ls_gnt_o,
    output logic          ls_rvalid_o,
    output logic [31:0]   ls_rdata_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i,
    output logic          stall_o
);

    // LAT is meant to stay within 1..4, so a 2-bit wait counter is enough.
    localparam logic [1:0] CNT_LOAD  = 2'(LAT - 1);
    localparam logic       MULTI_CYC = (LAT > 1) ? 1'b1 : 1'b0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t         state_r;
    state_t         state_next_s;
    logic [1:0]     cnt_r;
    logic           pri_if_r;
    logic [LAT-1:0] tag_vld_r;
    logic [LAT-1:0] tag_own_r;   // 1 = load/store owns the read, 0 = fetch
    logic           if_gnt_s;
    logic           ls_gnt_s;
    logic           rd_gnt_s;

    // Grant selection. Grants are allowed only in IDLE and never during reset.
    always_comb begin
        if_gnt_s = 1'b0;
        ls_gnt_s = 1'b0;
        if (rst_n_i && (state_r == ST_IDLE)) begin
            if (if_req_i && ls_req_i) begin
                if (pri_if_r) begin
                    if_gnt_s = 1'b1;
                end else begin
                    ls_gnt_s = 1'b1;
                end
            end else begin
                if_gnt_s = if_req_i;
                ls_gnt_s = ls_req_i;
            end
        end else begin
            if_gnt_s = 1'b0;
            ls_gnt_s = 1'b0;
        end
    end

    assign rd_gnt_s = if_gnt_s | (ls_gnt_s & ~ls_we_i);

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state. A read with LAT>1 parks the arbiter until the data returns.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rd_gnt_s && MULTI_CYC) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r <= 2'd1) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs. The memory strobe and operands follow the granted requester.
    always_comb begin
        if_gnt_o    = if_gnt_s;
        ls_gnt_o    = ls_gnt_s;
        mem_en_o    = if_gnt_s | ls_gnt_s;
        mem_we_o    = ls_gnt_s & ls_we_i;
        mem_addr_o  = {AW{1'b0}};
        mem_wdata_o = 32'h0000_0000;
        if (ls_gnt_s) begin
            mem_addr_o = ls_addr_i;
            if (ls_we_i) begin
                mem_wdata_o = ls_wdata_i;
            end else begin
                mem_wdata_o = 32'h0000_0000;
            end
        end else if (if_gnt_s) begin
            mem_addr_o = if_addr_i;
        end else begin
            mem_addr_o = {AW{1'b0}};
        end
        stall_o = rst_n_i & if_req_i & ~if_gnt_s;
    end

    // The wait counter loads LAT-1 on a read grant and counts down in WAIT.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_r <= 2'd0;
        end else if ((state_r == ST_IDLE) && rd_gnt_s && MULTI_CYC) begin
            cnt_r <= CNT_LOAD;
        end else if ((state_r == ST_WAIT) && (cnt_r != 2'd0)) begin
            cnt_r <= cnt_r - 2'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Fairness flag: fetch goes first after load/store has won a contended cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pri_if_r <= 1'b0;
        end else if (if_gnt_s) begin
            pri_if_r <= 1'b0;
        end else if (ls_gnt_s && if_req_i) begin
            pri_if_r <= 1'b1;
        end else begin
            pri_if_r <= pri_if_r;
        end
    end

    // Read ownership pipeline. Its last stage lines up with the memory data.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tag_vld_r <= {LAT{1'b0}};
            tag_own_r <= {LAT{1'b0}};
        end else begin
            tag_vld_r[0] <= rd_gnt_s;
            tag_own_r[0] <= ls_gnt_s;
            for (int i = 1; i < LAT; i++) begin
                tag_vld_r[i] <= tag_vld_r[i-1];
                tag_own_r[i] <= tag_own_r[i-1];
            end
        end
    end

    // Response steering. Read data is forced to zero when it is not valid for that port.
    always_comb begin
        if_rvalid_o = tag_vld_r[LAT-1] & ~tag_own_r[LAT-1];
        ls_rvalid_o = tag_vld_r[LAT-1] &  tag_own_r[LAT-1];
        if (if_rvalid_o) begin
            if_rdata_o = mem_rdata_i;
        end else begin
            if_rdata_o = 32'h0000_0000;
        end
        if (ls_rvalid_o) begin
            ls_rdata_o = mem_rdata_i;
        end else begin
            ls_rdata_o = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (LAT = 1, 3, 4) share one stimulus.
// Each instance has its own behavioural memory that returns addr ^ 0xC0DE0000
// LAT cycles after the address was presented. Read responses are scoreboarded.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;

    logic        if_gnt    [3];
    logic        if_rvalid [3];
    logic [31:0] if_rdata  [3];
    logic        ls_gnt    [3];
    logic        ls_rvalid [3];
    logic [31:0] ls_rdata  [3];
    logic        mem_en    [3];
    logic        mem_we    [3];
    logic [31:0] mem_addr  [3];
    logic [31:0] mem_wdata [3];
    logic [31:0] mem_rdata [3];
    logic        stall     [3];
    logic [31:0] mpipe     [3][4];

    typedef struct {
        int          due;
        logic        own_ls;
        logic [31:0] data;
    } sb_t;

    sb_t sb_q[$];

    int n_tests;
    int n_fail;
    int sel;
    int cyc;

    logic        o_if_gnt, o_ls_gnt, o_mem_en, o_mem_we, o_stall;
    logic        o_if_rvalid, o_ls_rvalid;
    logic [31:0] o_mem_addr, o_mem_wdata, o_if_rdata, o_ls_rdata;

    mem_port_arbiter #(.AW(32), .LAT(1)) dut_l1 (
        .clk_i(clk), .rst_n_i(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt[0]),
        .if_rvalid_o(if_rvalid[0]), .if_rdata_o(if_rdata[0]),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
        .ls_gnt_o(ls_gnt[0]), .ls_rvalid_o(ls_rvalid[0]), .ls_rdata_o(ls_rdata[0]),
        .mem_en_o(mem_en[0]), .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]),
        .mem_wdata_o(mem_wdata[0]), .mem_rdata_i(mem_rdata[0]), .stall_o(stall[0])
    );

    mem_port_arbiter #(.AW(32), .LAT(3)) dut_l3 (
        .clk_i(clk), .rst_n_i(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt[1]),
        .if_rvalid_o(if_rvalid[1]), .if_rdata_o(if_rdata[1]),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
        .ls_gnt_o(ls_gnt[1]), .ls_rvalid_o(ls_rvalid[1]), .ls_rdata_o(ls_rdata[1]),
        .mem_en_o(mem_en[1]), .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]),
        .mem_wdata_o(mem_wdata[1]), .mem_rdata_i(mem_rdata[1]), .stall_o(stall[1])
    );

    mem_port_arbiter #(.AW(32), .LAT(4)) dut_l4 (
        .clk_i(clk), .rst_n_i(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt[2]),
        .if_rvalid_o(if_rvalid[2]), .if_rdata_o(if_rdata[2]),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
        .ls_gnt_o(ls_gnt[2]), .ls_rvalid_o(ls_rvalid[2]), .ls_rdata_o(ls_rdata[2]),
        .mem_en_o(mem_en[2]), .mem_we_o(mem_we[2]), .mem_addr_o(mem_addr[2]),
        .mem_wdata_o(mem_wdata[2]), .mem_rdata_i(mem_rdata[2]), .stall_o(stall[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Behavioural memories: the presented address is delayed, then mapped to data.
    always_ff @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            mpipe[d][0] <= mem_addr[d];
            for (int k = 1; k < 4; k++) begin
                mpipe[d][k] <= mpipe[d][k-1];
            end
        end
    end

    assign mem_rdata[0] = mem_f(mpipe[0][0]);
    assign mem_rdata[1] = mem_f(mpipe[1][2]);
    assign mem_rdata[2] = mem_f(mpipe[2][3]);

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (cyc %0d): observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (cyc %0d): observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_in(input logic ir, input logic [31:0] ia, input logic lr,
                          input logic lw, input logic [31:0] la, input logic [31:0] ld);
        if_req   = ir;
        if_addr  = ia;
        ls_req   = lr;
        ls_we    = lw;
        ls_addr  = la;
        ls_wdata = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic samp();
        @(negedge clk);
        o_if_gnt    = if_gnt[sel];
        o_ls_gnt    = ls_gnt[sel];
        o_mem_en    = mem_en[sel];
        o_mem_we    = mem_we[sel];
        o_mem_addr  = mem_addr[sel];
        o_mem_wdata = mem_wdata[sel];
        o_stall     = stall[sel];
        o_if_rvalid = if_rvalid[sel];
        o_ls_rvalid = ls_rvalid[sel];
        o_if_rdata  = if_rdata[sel];
        o_ls_rdata  = ls_rdata[sel];
    endtask

    task automatic chk_port(input string t, input logic ig, input logic lg,
                            input logic [31:0] a, input logic st);
        chk1({t, "_if_gnt"}, o_if_gnt, ig);
        chk1({t, "_ls_gnt"}, o_ls_gnt, lg);
        chk1({t, "_mem_en"}, o_mem_en, ig | lg);
        chk32({t, "_mem_addr"}, o_mem_addr, a);
        chk1({t, "_stall"}, o_stall, st);
    endtask

    task automatic push_rd(input logic own_ls, input logic [31:0] a, input int due);
        sb_t e;
        e.due    = due;
        e.own_ls = own_ls;
        e.data   = mem_f(a);
        sb_q.push_back(e);
    endtask

    // Pops the expected response due this cycle, if any; otherwise both rvalids must be low.
    task automatic sb_check();
        sb_t  e;
        logic exp_if;
        logic exp_ls;
        exp_if = 1'b0;
        exp_ls = 1'b0;
        e.due = 0; e.own_ls = 1'b0; e.data = 32'h0;
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            exp_if = ~e.own_ls;
            exp_ls = e.own_ls;
        end
        chk1("if_rvalid", o_if_rvalid, exp_if);
        chk1("ls_rvalid", o_ls_rvalid, exp_ls);
        if (exp_if) chk32("if_rdata", o_if_rdata, e.data);
        if (exp_ls) chk32("ls_rdata", o_ls_rdata, e.data);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        sel     = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        // Reset state: requests are active but every output must stay at zero.
        set_in(1'b1, 32'h0000_0111, 1'b1, 1'b1, 32'h0000_0222, 32'h1234_5678);
        for (int d = 0; d < 3; d++) begin
            sel = d;
            samp();
            chk_port("rst", 1'b0, 1'b0, 32'h0, 1'b0);
            chk1("rst_mem_we", o_mem_we, 1'b0);
            chk32("rst_mem_wdata", o_mem_wdata, 32'h0);
            chk1("rst_if_rvalid", o_if_rvalid, 1'b0);
            chk1("rst_ls_rvalid", o_ls_rvalid, 1'b0);
            chk32("rst_if_rdata", o_if_rdata, 32'h0);
            chk32("rst_ls_rdata", o_ls_rdata, 32'h0);
        end

        // LAT=1: a lone fetch is granted at once and its data returns one cycle later.
        sel = 0;
        do_reset();
        set_in(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0);
        samp(); chk_port("a_c0", 1'b1, 1'b0, 32'h0000_0100, 1'b0); sb_check();
        push_rd(1'b0, 32'h0000_0100, cyc + 1);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        samp(); chk_port("a_c1", 1'b0, 1'b0, 32'h0, 1'b0); sb_check();
        tick(); samp(); sb_check();

        // LAT=1: with both requesters contending, the grants alternate LS, IF, LS.
        do_reset();
        set_in(1'b1, 32'h0000_0104, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
        samp(); chk_port("b_c0", 1'b0, 1'b1, 32'h0000_0200, 1'b1); sb_check();
        push_rd(1'b1, 32'h0000_0200, cyc + 1);
        tick();
        samp(); chk_port("b_c1", 1'b1, 1'b0, 32'h0000_0104, 1'b0); sb_check();
        push_rd(1'b0, 32'h0000_0104, cyc + 1);
        tick();
        samp(); chk_port("b_c2", 1'b0, 1'b1, 32'h0000_0200, 1'b1); sb_check();
        push_rd(1'b1, 32'h0000_0200, cyc + 1);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        samp(); chk_port("b_c3", 1'b0, 1'b0, 32'h0, 1'b0); sb_check();
        tick(); samp(); sb_check();

        // LAT=3: a load blocks the pending fetch until the load data returns.
        sel = 1;
        do_reset();
        set_in(1'b1, 32'h0000_0108, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
        samp(); chk_port("c_c0", 1'b0, 1'b1, 32'h0000_0300, 1'b1); sb_check();
        push_rd(1'b1, 32'h0000_0300, cyc + 3);
        tick();
        set_in(1'b1, 32'h0000_0108, 1'b0, 1'b0, 32'h0, 32'h0);
        samp(); chk_port("c_c1", 1'b0, 1'b0, 32'h0, 1'b1); sb_check();
        tick();
        samp(); chk_port("c_c2", 1'b0, 1'b0, 32'h0, 1'b1); sb_check();
        tick();
        samp(); chk_port("c_c3", 1'b1, 1'b0, 32'h0000_0108, 1'b0); sb_check();
        push_rd(1'b0, 32'h0000_0108, cyc + 3);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int c = 4; c <= 7; c++) begin
            samp(); chk1("c_mem_en", o_mem_en, 1'b0); sb_check();
            tick();
        end

        // LAT=3: a store completes in its grant cycle and leaves the arbiter in IDLE.
        do_reset();
        set_in(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0400, 32'hDEAD_BEEF);
        samp(); chk_port("d_c0", 1'b0, 1'b1, 32'h0000_0400, 1'b0); sb_check();
        chk1("d_c0_mem_we", o_mem_we, 1'b1);
        chk32("d_c0_mem_wdata", o_mem_wdata, 32'hDEAD_BEEF);
        tick();
        set_in(1'b1, 32'h0000_010C, 1'b0, 1'b0, 32'h0, 32'h0);
        samp(); chk_port("d_c1", 1'b1, 1'b0, 32'h0000_010C, 1'b0); sb_check();
        chk1("d_c1_mem_we", o_mem_we, 1'b0);
        push_rd(1'b0, 32'h0000_010C, cyc + 3);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int c = 2; c <= 5; c++) begin
            samp(); sb_check();
            tick();
        end

        // LAT=4: a reset pulse discards the outstanding load; a fetch follows the release.
        sel = 2;
        do_reset();
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0500, 32'h0);
        samp(); chk_port("e_c0", 1'b0, 1'b1, 32'h0000_0500, 1'b0); sb_check();
        tick();
        set_in(1'b1, 32'h0000_0110, 1'b0, 1'b0, 32'h0, 32'h0);
        samp(); chk_port("e_c1", 1'b0, 1'b0, 32'h0, 1'b1); sb_check();
        tick();
        rst_n = 1'b0;
        samp(); chk_port("e_c2", 1'b0, 1'b0, 32'h0, 1'b0); sb_check();
        chk32("e_c2_if_rdata", o_if_rdata, 32'h0);
        chk32("e_c2_ls_rdata", o_ls_rdata, 32'h0);
        tick();
        rst_n = 1'b1;
        samp(); chk_port("e_c3", 1'b1, 1'b0, 32'h0000_0110, 1'b0); sb_check();
        push_rd(1'b0, 32'h0000_0110, cyc + 4);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int c = 4; c <= 8; c++) begin
            samp(); sb_check();
            tick();
        end

        chk32("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, default 32, address width in bits.
REQ-002 Parameter LAT, default 1, memory read latency in cycles, legal range 1..4.
REQ-003 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n_i  in  1  reset; asynchronous and active-low.
REQ-005 if_req_i  in  1  instruction-fetch read request.
REQ-006 if_addr_i  in  AW  fetch address.
REQ-007 if_gnt_o  out  1  fetch request accepted this cycle.
REQ-008 if_rvalid_o  out  1  fetch read data valid.
REQ-009 if_rdata_o  out  32  fetch read data.
REQ-010 ls_req_i  in  1  load/store request.
REQ-011 ls_we_i  in  1  1 = store, 0 = load.
REQ-012 ls_addr_i  in  AW  load/store address.
REQ-013 ls_wdata_i  in  32  store data.
REQ-014 ls_gnt_o  out  1  load/store request accepted this cycle.
REQ-015 ls_rvalid_o  out  1  load data valid.
REQ-016 ls_rdata_o  out  32  load data.
REQ-017 mem_en_o, mem_we_o  out  1 each  memory access strobe and write enable.
REQ-018 mem_addr_o  out  AW, mem_wdata_o  out  32  memory address and write data.
REQ-019 mem_rdata_i  in  32  memory read data, valid LAT cycles after a read strobe.
REQ-020 stall_o  out  1  fetch blocked: if_req_i high and if_gnt_o low.

Function
REQ-021 The block SHALL share one single-port memory between the fetch and load/store requesters and issue at most one access per cycle.
REQ-022 States SHALL be IDLE (grants allowed) and WAIT (read outstanding, no grants).
REQ-023 In IDLE, grants SHALL be combinational in the request cycle; mem_en_o = if_gnt_o | ls_gnt_o; mem_addr_o, mem_we_o and mem_wdata_o SHALL be taken from the granted requester.
REQ-024 With exactly one requester active, that requester SHALL be granted.
REQ-025 With both requesters active, load/store SHALL win unless flag pri_if is set, in which case fetch SHALL win.
REQ-026 pri_if SHALL set when load/store wins a contended cycle and clear when fetch is granted.
REQ-027 A store SHALL complete in its grant cycle, produce no rvalid, and keep the FSM in IDLE.
REQ-028 A read granted in cycle T SHALL assert the owner's rvalid for exactly one cycle, at T+LAT.
REQ-029 After a read grant with LAT>1, the FSM SHALL enter WAIT and load counter cnt with LAT-1; cnt SHALL decrement each cycle; the FSM SHALL return to IDLE when cnt reaches 0, so a new grant is possible in cycle T+LAT.
REQ-030 With LAT=1, the FSM SHALL stay in IDLE, allowing back-to-back reads every cycle.
REQ-031 The owner of each read SHALL be carried in a LAT-deep {valid, owner} tag pipeline; rvalid SHALL follow the tag, never the current grant.
REQ-032 if_rdata_o and ls_rdata_o SHALL both be driven from mem_rdata_i and are meaningful only while the matching rvalid is high.
REQ-033 In WAIT, both grants and mem_en_o SHALL be 0; requesters SHALL hold request and address stable until granted.
REQ-034 if_rvalid_o and ls_rvalid_o SHALL never be high in the same cycle.

Reset
REQ-035 While rst_n_i is low, all outputs SHALL be 0, the FSM SHALL be IDLE, and cnt, pri_if and the tag pipeline SHALL be cleared.
REQ-036 A reset asserted during an outstanding read SHALL discard that read; no rvalid for it SHALL appear after reset release.

Verification
REQ-037 LAT=1, if_req_i=1 at 0x100 alone -> if_gnt_o=1 and mem_addr_o=0x100 in cycle 0; if_rvalid_o=1 with if_rdata_o=mem_rdata_i in cycle 1; stall_o=0.
REQ-038 LAT=1, both request for 3 cycles (load 0x200, fetch 0x104) -> grant order LS, IF, LS; stall_o=1 in cycles 0 and 2.
REQ-039 LAT=3, load 0x300 granted in cycle 0 while fetch is pending -> no grants and stall_o=1 in cycles 1-2; ls_rvalid_o=1 and if_gnt_o=1 in cycle 3.
REQ-040 Store 0x400 with data 0xDEADBEEF in cycle 0, fetch in cycle 1 -> mem_we_o=1 with that data in cycle 0; no rvalid for the store; fetch granted in cycle 1.
REQ-041 LAT=4, rst_n_i pulsed low in cycle 2 after a read grant in cycle 0 -> all outputs 0 during reset; no rvalid in cycles 2-6; a fetch is granted in the first cycle after reset release.
